alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined integer ALU for the execute stage; successor of the 1-bit-op add/sub ALU.
//  Adds logic, compare and shift ops, status flags and a valid/ready handshake with backpressure.
//  Two register stages: operand capture (S1) -> result (S2). Optional iterative multiplier.
// PARAMETERS
//  DATA_W   32  operand/result width; power of 2, >= 8
//  OP_W     4   opcode width (codes from alu_pkg)
//  SH_W     $clog2(DATA_W)  shift-amount width (derived, localparam)
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous reset, active low
//  in_valid    in   1       operand beat valid
//  in_ready    out  1       S1 can accept a beat
//  in_op       in   OP_W    opcode
//  in_a        in   DATA_W  operand 1
//  in_b        in   DATA_W  operand 2 (shift amount = in_b[SH_W-1:0])
//  out_valid   out  1       result beat valid
//  out_ready   in   1       consumer accepts result
//  out_result  out  DATA_W  result
//  out_zero    out  1       out_result == 0
//  out_carry   out  1       ADD: carry-out; SUB: 1 = no borrow (a >= b unsigned); else 0
//  out_ovf     out  1       signed overflow, ADD/SUB only; else 0
//  out_err     out  1       illegal opcode; result forced 0
//  busy        out  1       multiplier FSM active (tied 0 without MUL_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_result=0, all flags 0, FSM IDLE, busy=0.
//  Opcodes: 0 ADD, 1 SUB (codes 0/1 match old add/sub op bit), 2 AND, 3 OR, 4 XOR, 5 NOR,
//   6 SLT (signed, result 1/0), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MUL (low DATA_W bits), 12-15 illegal.
//  Handshake: transfer on valid&&ready, both sides. in_valid/data held stable until in_ready.
//   out_valid stays high and out_* stable until out_ready.
//  S2 load: s2_load = s1_valid && s1_done && (!out_valid || out_ready).
//  in_ready = !s1_valid || s2_load  (combinational; no bubble when stream flows).
//  Latency: single-cycle ops: beat accepted at edge N -> out_valid at edge N+1 (visible cycle after).
//   Throughput 1 beat/cycle with out_ready=1.
//  s1_done = 1 for all non-MUL ops; for MUL only when FSM reaches DONE.
//  Arithmetic: ADD/SUB computed in DATA_W+1 bits; ovf = operands' signs per op differ from result sign.
//   Shifts use only low SH_W bits of b; SRA replicates a[DATA_W-1].
//  Backpressure: out_valid&&!out_ready -> S2 holds, S1 holds if full, in_ready=0 once S1 full.
//  Simultaneous out_ready and new S1 beat: S2 reloads same cycle, no lost or duplicated beat.
//  Reset mid-operation: all in-flight beats (S1, S2, MUL) discarded; no output after deassert
//   until a new beat is accepted.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL via shift-add FSM IDLE -> RUN (DATA_W cycles, 1 bit/cycle) -> DONE -> IDLE
//   on s2_load. busy=1 in RUN/DONE. S1 stalls while RUN; MUL latency = DATA_W+1 cycles to out_valid.
//   Flags after MUL: zero valid, carry/ovf 0.
//  ALU_MUL_EN undefined: opcode 11 is illegal (result 0, out_err=1, latency 1); busy tied 0.
// STRUCTURE
//  alu_pkg: opcode localparams (ALU_ADD..ALU_MUL), OP_W, illegal-op range check function.
//  Sub-module alu_mul_seq (iterative multiplier: start, a, b -> done, product), instantiated only
//   under ALU_MUL_EN. Combinational op decode and flag logic stay in alu_pipe.
// TESTING
//  1 Reset: rst_n low mid-stream with S1,S2 full -> out_valid=0, in_ready=1, no stale beat after release.
//  2 Directed ops, DATA_W=32: ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1, carry=0;
//    SUB 5-5 -> 0, zero=1, carry=1; SLT -1,1 -> 1; SLTU -1,1 -> 0; SRA 0x80000000>>4 -> 0xF8000000.
//  3 Streaming 100 random beats, out_ready=1 -> one result per cycle, order preserved, latency 1.
//  4 Backpressure: out_ready random 30% -> no drop/duplicate vs reference model; out_* stable while stalled.
//  5 Illegal op 13 -> result 0, out_err=1; op 11 without ALU_MUL_EN -> out_err=1.
//  6 ALU_MUL_EN: 0xFFFF*0x10001 -> 0xFFFFFFFF after 33 cycles, busy high throughout, in_ready=0
//    while next beat waits; following ADD completes 1 cycle after MUL leaves S1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute-stage ALU.
// Build option: ALU_MUL_EN enables opcode 11 (iterative multiply).
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'd11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Opcodes above the last implemented one are illegal; MUL only exists when built in.
  function automatic logic alu_op_illegal(input logic [ALU_OP_W-1:0] op);
`ifdef ALU_MUL_EN
    return (op > ALU_MUL);
`else
    return (op >= ALU_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one multiplier bit per cycle, low DATA_W bits of the product.
// Operands are latched on start; the product is held in DONE until acknowledged.
// A new start may be accepted in the same cycle as the acknowledge.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mul_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state and datapath update for the multiply sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          state_d  = MUL_RUN;
          acc_d    = '0;
          mcand_d  = a_i;
          mplier_d = b_i;
          cnt_d    = '0;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = MUL_DONE;
        end else begin
          state_d = MUL_RUN;
        end
      end
      MUL_DONE: begin
        if (ack_i && start_i) begin
          state_d  = MUL_RUN;
          acc_d    = '0;
          mcand_d  = a_i;
          mplier_d = b_i;
          cnt_d    = '0;
        end else if (ack_i) begin
          state_d = MUL_IDLE;
        end else begin
          state_d = MUL_DONE;
        end
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done_o    = (state_q == MUL_DONE);
  assign busy_o    = (state_q != MUL_IDLE);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshake on both sides.
// S1 captures operands, S2 holds the registered result and flags.
// Build option: ALU_MUL_EN adds an iterative multiplier (opcode 11) that stalls S1.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   in_op_i,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_result_o,
  output logic              out_zero_o,
  output logic              out_carry_o,
  output logic              out_ovf_o,
  output logic              out_err_o,
  output logic              busy_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic              s1_valid_q;
  logic [OP_W-1:0]   s1_op_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;

  logic              out_valid_q, zero_q, carry_q, ovf_q, err_q;
  logic [DATA_W-1:0] result_q;

  logic              in_fire_s, s1_done_s, s2_load_s;
  logic [DATA_W:0]   sum_s, diff_s;
  logic [SH_W-1:0]   shamt_s;
  logic [DATA_W-1:0] res_s;
  logic              carry_s, ovf_s, err_s, zero_s;

`ifdef ALU_MUL_EN
  logic              mul_start_s, mul_done_s;
  logic [DATA_W-1:0] mul_product_s;

  assign mul_start_s = in_fire_s && (in_op_i == ALU_MUL);

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start_s),
    .ack_i     (s2_load_s),
    .a_i       (in_a_i),
    .b_i       (in_b_i),
    .done_o    (mul_done_s),
    .busy_o    (busy_o),
    .product_o (mul_product_s)
  );

  assign s1_done_s = (s1_op_q != ALU_MUL) || mul_done_s;
`else
  assign s1_done_s = 1'b1;
  assign busy_o    = 1'b0;
`endif

  assign s2_load_s  = s1_valid_q && s1_done_s && (!out_valid_q || out_ready_i);
  assign in_ready_o = !s1_valid_q || s2_load_s;
  assign in_fire_s  = in_valid_i && in_ready_o;

  assign sum_s   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign diff_s  = {1'b0, s1_a_q} - {1'b0, s1_b_q};
  assign shamt_s = s1_b_q[SH_W-1:0];

  // Opcode decode, result mux and status flags for the beat held in S1.
  always_comb begin
    res_s   = '0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (s1_op_q)
      ALU_ADD: begin
        res_s   = sum_s[DATA_W-1:0];
        carry_s = sum_s[DATA_W];
        ovf_s   = (s1_a_q[DATA_W-1] == s1_b_q[DATA_W-1]) &&
                  (sum_s[DATA_W-1] != s1_a_q[DATA_W-1]);
      end
      ALU_SUB: begin
        res_s   = diff_s[DATA_W-1:0];
        carry_s = !diff_s[DATA_W];
        ovf_s   = (s1_a_q[DATA_W-1] != s1_b_q[DATA_W-1]) &&
                  (diff_s[DATA_W-1] != s1_a_q[DATA_W-1]);
      end
      ALU_AND:  res_s = s1_a_q & s1_b_q;
      ALU_OR:   res_s = s1_a_q | s1_b_q;
      ALU_XOR:  res_s = s1_a_q ^ s1_b_q;
      ALU_NOR:  res_s = ~(s1_a_q | s1_b_q);
      ALU_SLT:  res_s = {{(DATA_W-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      ALU_SLTU: res_s = {{(DATA_W-1){1'b0}}, (s1_a_q < s1_b_q)};
      ALU_SLL:  res_s = s1_a_q << shamt_s;
      ALU_SRL:  res_s = s1_a_q >> shamt_s;
      ALU_SRA:  res_s = DATA_W'($signed(s1_a_q) >>> shamt_s);
`ifdef ALU_MUL_EN
      ALU_MUL:  res_s = mul_product_s;
`endif
      default:  res_s = '0;
    endcase
    err_s  = alu_op_illegal(s1_op_q);
    zero_s = (res_s == '0);
  end

  // S1 operand capture: fills on an accepted beat, empties when S2 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (in_fire_s) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= in_op_i;
      s1_a_q     <= in_a_i;
      s1_b_q     <= in_b_i;
    end else if (s2_load_s) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2 result register: loads a finished S1 beat, otherwise holds until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (s2_load_s) begin
      out_valid_q <= 1'b1;
      result_q    <= res_s;
      zero_q      <= zero_s;
      carry_q     <= carry_s;
      ovf_q       <= ovf_s;
      err_q       <= err_s;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_result_o = result_q;
  assign out_zero_o   = zero_q;
  assign out_carry_o  = carry_q;
  assign out_ovf_o    = ovf_q;
  assign out_err_o    = err_q;

endmodule
